// File: rtl/dev_output_ctrl_if.sv
// ----------------------------------------------------------------------------
// dev_output_ctrl_if
//   Requester-side bus of the two-master output-device write controller.
//
//   req     [1:0]  level request per master, held until that master's ack
//   wdata0  [DW]   master 0 write data
//   wdata1  [DW]   master 1 write data
//   ack     [1:0]  one-cycle completion pulse per master
//   busy           controller is serving a transaction
//   gnt_id         master being served (valid while busy)
//
//   modport master : requester side (drives req/wdata, sees ack/busy/gnt_id)
//   modport slave  : controller side
// ----------------------------------------------------------------------------
interface dev_output_ctrl_if #(
  parameter int DW = 32
);
  logic [1:0]    req;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic [1:0]    ack;
  logic          busy;
  logic          gnt_id;

  modport master (
    output req, wdata0, wdata1,
    input  ack, busy, gnt_id
  );

  modport slave (
    input  req, wdata0, wdata1,
    output ack, busy, gnt_id
  );
endinterface

// File: rtl/dev_output_ctrl.sv
// ----------------------------------------------------------------------------
// dev_output_ctrl
//   Two-master write controller for a 2-register output device holding a
//   previous (pre, sel=00) and current (cur, sel=01) value. Every accepted
//   write performs a history shift: old cur is read and copied into pre,
//   then the new data is written into cur. A round-robin arbiter shares the
//   device between master 0 (CPU store path) and master 1 (debug/DMA).
//
//   Parameters
//     DW     data width (matches device width)
//     CW     width of the completed-write counter (wraps)
//     FIRST  master that wins the first tie after reset
//
//   Ports
//     clk       system clock, rising edge
//     rst       asynchronous active-low reset
//     bus       requester bus (req/wdata0/wdata1 in, ack/busy/gnt_id out)
//     dev_en    device write enable
//     dev_sel   device select (00 pre, 01 cur, 10 idle)
//     dev_din   device write data
//     dev_dout  device read data (combinational from dev_sel)
//     wcount    completed-write counter
// ----------------------------------------------------------------------------
module dev_output_ctrl #(
  parameter int DW    = 32,
  parameter int CW    = 16,
  parameter int FIRST = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  dev_output_ctrl_if.slave      bus,
  output logic                  dev_en,
  output logic [1:0]            dev_sel,
  output logic [DW-1:0]         dev_din,
  input  logic [DW-1:0]         dev_dout,
  output logic [CW-1:0]         wcount
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CAPT  = 3'd1,
    SHIFT = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_t;

  // The pointer holds the last master served; starting it at the other
  // master makes FIRST win the first tie.
  localparam logic LAST_RST = (FIRST == 0) ? 1'b1 : 1'b0;

  state_t        state_q, state_d;
  logic          gnt_q,   gnt_d;
  logic          last_q,  last_d;
  logic [DW-1:0] wbuf_q,  wbuf_d;
  logic [DW-1:0] snap_q,  snap_d;
  logic [CW-1:0] wcount_q, wcount_d;

  logic          win;
  logic [1:0]    ack_c;
  logic          en_c;
  logic [1:0]    sel_c;
  logic [DW-1:0] din_c;

  // Arbitration: a lone requester wins; on a tie the master not served last.
  always_comb begin
    if (bus.req == 2'b11) win = ~last_q;
    else                  win = bus.req[1];
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt_q    <= 1'b0;
      last_q   <= LAST_RST;
      wbuf_q   <= '0;
      snap_q   <= '0;
      wcount_q <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      wbuf_q   <= wbuf_d;
      snap_q   <= snap_d;
      wcount_q <= wcount_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    wbuf_d   = wbuf_q;
    snap_d   = snap_q;
    wcount_d = wcount_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = win;
          wbuf_d  = win ? bus.wdata1 : bus.wdata0;
          state_d = CAPT;
        end
      end
      CAPT: begin
        // dev_sel=01 here, so dev_dout is the old cur value.
        snap_d  = dev_dout;
        state_d = SHIFT;
      end
      SHIFT: state_d = WRITE;
      WRITE: state_d = DONE;
      DONE: begin
        wcount_d = wcount_q + {{(CW-1){1'b0}}, 1'b1};
        last_d   = gnt_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    en_c  = 1'b0;
    sel_c = 2'b10;
    din_c = '0;
    ack_c = 2'b00;
    unique case (state_q)
      CAPT:  sel_c = 2'b01;
      SHIFT: begin
        sel_c = 2'b00;
        en_c  = 1'b1;
        din_c = snap_q;
      end
      WRITE: begin
        sel_c = 2'b01;
        en_c  = 1'b1;
        din_c = wbuf_q;
      end
      DONE:  ack_c = gnt_q ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  assign dev_en     = en_c;
  assign dev_sel    = sel_c;
  assign dev_din    = din_c;
  assign wcount     = wcount_q;
  assign bus.ack    = ack_c;
  assign bus.busy   = (state_q != IDLE);
  assign bus.gnt_id = gnt_q;

endmodule

// File: doc/dev_output_ctrl.md
Name: dev_output_ctrl

Overview:
- Two-master write controller for the 2-register output device, which holds a previous and a current 32-bit value.
  - Device select 00 addresses the previous register (pre); 01 addresses the current register (cur).
  - Device output is combinational from its select.
- Each accepted write runs a history shift: the old cur is copied into pre, then the new data is written to cur.
- A round-robin arbiter shares the device between master 0 (CPU store path) and master 1 (debug/DMA).
- Sits between the bus-side requesters and the device's en/sel/din/dout pins.

Parameters:
- DW, 32, data width; must match the device width.
- CW, 16, width of the completed-write counter.
- FIRST, 0, master that wins the first simultaneous request after reset (0 or 1).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk).
- req  in  2  level request per master; held until that master's ack.
- wdata0  in  DW  master 0 write data.
- wdata1  in  DW  master 1 write data.
- ack  out  2  one-cycle completion pulse per master.
- busy  out  1  high whenever the FSM is not in IDLE.
- gnt_id  out  1  master currently being served; valid while busy=1.
- dev_en  out  1  device write enable.
- dev_sel  out  2  device select.
- dev_din  out  DW  device write data.
- dev_dout  in  DW  device read data.
- wcount  out  CW  count of completed writes; wraps modulo 2^CW.

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE.
  - ack=0, busy=0, gnt_id=0, dev_en=0, dev_sel=2'b10, dev_din=0, wcount=0.
  - Round-robin pointer set so that FIRST wins the next tie.
  - Latched data and snapshot cleared.
  - The controller does not clear device contents.
- FSM states and per-state outputs:
  - IDLE: dev_en=0, dev_sel=10. If any req bit is 1 at an edge:
    - choose the winner;
    - latch its wdata into wbuf;
    - set gnt_id;
    - go to CAPT.
  - CAPT: dev_sel=01, dev_en=0. At the edge, snap<=dev_dout; go to SHIFT.
  - SHIFT: dev_sel=00, dev_en=1, dev_din=snap; go to WRITE.
  - WRITE: dev_sel=01, dev_en=1, dev_din=wbuf; go to DONE.
  - DONE: ack[gnt_id]=1 for exactly this cycle; wcount increments at the exit edge; pointer records gnt_id; go to IDLE.
- dev_en is high only in SHIFT and WRITE; dev_din=0 in all other states.
- All outputs are registered or decoded from registered state, with no combinational path from req.
- Latency: req sampled in IDLE at edge E0 -> ack high in the cycle after edge E0+3.
  - One transaction takes 5 cycles including IDLE.
  - Back-to-back service: the next grant is decided at the IDLE edge after DONE.
- Arbitration:
  - Only one requester: it wins.
  - Both requesters: the master not granted last wins.
  - Requests arriving during busy wait; req is never dropped by the controller.
- Requester rule:
  - Deassert req on the edge ending the ack cycle.
  - If req is still 1 in the IDLE cycle after DONE, it is a new request.
  - wdata is captured at the grant edge; later changes have no effect on the transaction.
- wcount: after 2^CW-1 it wraps to 0; there is no saturation and no flag.
- Reset mid-transaction: the FSM aborts to IDLE with no ack.
  - Reset after SHIFT but before WRITE leaves pre updated and cur stale; this is accepted.
- req bits that fall without an ack (protocol violation) are ignored once granted; the transaction completes and ack still pulses.

Test Plan:
- Reset, then master 0 writes 0xA5A5A5A5 from an initial device pre=cur=0.
  - Required: dev_sel sequence 10,01,00,01,10.
  - Required: SHIFT din=0; WRITE din=0xA5A5A5A5.
  - Required: ack=01 exactly once, 4 cycles after the request edge; wcount=1.
- Master 0 writes 0x11, then 0x22.
  - Required: after the second write, device pre=0x11 and cur=0x22.
- Both req=11 held continuously after reset with FIRST=0.
  - Required: grants alternate 0,1,0,1; each master gets ack every 10 cycles; no master is starved.
- Master 1 changes wdata1 from 0x5 to 0x9 during CAPT.
  - Required: the device cur receives 0x5.
- rst pulled low during SHIFT.
  - Required: dev_en=0, busy=0, ack=00 immediately without a clock edge.
  - Required: after release, a new request completes normally.
- Preload wcount to 0xFFFF (CW=16) via 65535 writes or a force, then complete one write.
  - Required: wcount=0.
